// File: rtl/bno085_report_parser_if.sv
// Byte-stream input and decoded-sample output bundle between the SHTP SPI master
// and the BNO085 report parser.
interface bno085_report_parser_if;
  logic               pkt_start;
  logic               rx_valid;
  logic [7:0]         rx_byte;
  logic               quat_valid;
  logic signed [15:0] quat_w;
  logic signed [15:0] quat_x;
  logic signed [15:0] quat_y;
  logic signed [15:0] quat_z;
  logic               gyro_valid;
  logic signed [15:0] gyro_x;
  logic signed [15:0] gyro_y;
  logic signed [15:0] gyro_z;
  logic               parse_error;

  modport master (
    output pkt_start, rx_valid, rx_byte,
    input  quat_valid, quat_w, quat_x, quat_y, quat_z,
    input  gyro_valid, gyro_x, gyro_y, gyro_z, parse_error
  );

  modport slave (
    input  pkt_start, rx_valid, rx_byte,
    output quat_valid, quat_w, quat_x, quat_y, quat_z,
    output gyro_valid, gyro_x, gyro_y, gyro_z, parse_error
  );
endinterface

// File: rtl/bno085_report_parser.sv
// SHTP input-report decoder: pulls rotation-vector and calibrated-gyro samples out of
// the BNO085 byte stream and presents them as held registers with one-cycle strobes.
module bno085_report_parser #(
  parameter logic [7:0] SENSOR_CHANNEL = 8'd3,
  parameter logic [7:0] QUAT_REPORT_ID = 8'h05,
  parameter logic [7:0] GYRO_REPORT_ID = 8'h02
) (
  input  logic                 clk,
  input  logic                 rst,
  bno085_report_parser_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR, RID, BODY, SKIP} state_t;
  typedef enum logic [1:0] {K_TS, K_QUAT, K_GYRO} kind_t;

  state_t      r_state, w_state_next;
  kind_t       r_kind;
  logic [1:0]  r_hidx;
  logic [7:0]  r_b0, r_chan, r_lsb;
  logic [14:0] r_len, r_rem, w_rem_dec;
  logic [3:0]  r_bidx, w_body_last;
  logic [15:0] r_sh_qw, r_sh_qx, r_sh_qy, r_sh_qz, r_sh_gx, r_sh_gy, w_pair;
  logic [15:0] r_qw, r_qx, r_qy, r_qz, r_gx, r_gy, r_gz;
  logic        r_quat_valid, r_gyro_valid, r_err;
  logic        w_id_ts, w_id_quat, w_id_gyro, w_done_quat, w_done_gyro, w_err;

  assign w_rem_dec = r_rem - 15'd1;
  assign w_pair    = {bus.rx_byte, r_lsb};
  assign w_id_ts   = (bus.rx_byte == 8'hFB) || (bus.rx_byte == 8'hFA);
  assign w_id_quat = (bus.rx_byte == QUAT_REPORT_ID);
  assign w_id_gyro = (bus.rx_byte == GYRO_REPORT_ID);

  always_comb begin
    case (r_kind)
      K_QUAT:  w_body_last = 4'd13;
      K_GYRO:  w_body_last = 4'd9;
      default: w_body_last = 4'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Completion is tested before exhaustion so a report ending exactly on the packet boundary is good.
  always_comb begin
    w_state_next = r_state;
    w_done_quat  = 1'b0;
    w_done_gyro  = 1'b0;
    w_err        = 1'b0;
    if (bus.pkt_start) begin
      w_state_next = HDR;
    end else if (bus.rx_valid) begin
      case (r_state)
        HDR: if (r_hidx == 2'd3) begin
          if (r_len <= 15'd4) begin
            w_state_next = IDLE;
            w_err        = (r_len != 15'd0) && (r_len != 15'd4);
          end else if (r_chan != SENSOR_CHANNEL) begin
            w_state_next = SKIP;
          end else begin
            w_state_next = RID;
          end
        end
        RID: if (w_id_ts || w_id_quat || w_id_gyro) begin
          if (w_rem_dec == '0) begin
            w_state_next = IDLE;
            w_err        = 1'b1;
          end else begin
            w_state_next = BODY;
          end
        end else begin
          w_state_next = (w_rem_dec == '0) ? IDLE : SKIP;
        end
        BODY: if (r_bidx == w_body_last) begin
          w_done_quat  = (r_kind == K_QUAT);
          w_done_gyro  = (r_kind == K_GYRO);
          w_state_next = (w_rem_dec == '0) ? IDLE : RID;
        end else if (w_rem_dec == '0) begin
          w_state_next = IDLE;
          w_err        = 1'b1;
        end
        SKIP: if (w_rem_dec == '0) w_state_next = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kind <= K_TS;   r_hidx <= '0;  r_b0 <= '0;   r_chan <= '0;  r_lsb <= '0;
      r_len <= '0;      r_rem <= '0;   r_bidx <= '0;
      r_sh_qw <= '0;    r_sh_qx <= '0; r_sh_qy <= '0; r_sh_qz <= '0;
      r_sh_gx <= '0;    r_sh_gy <= '0;
      r_qw <= '0; r_qx <= '0; r_qy <= '0; r_qz <= '0;
      r_gx <= '0; r_gy <= '0; r_gz <= '0;
      r_quat_valid <= 1'b0; r_gyro_valid <= 1'b0; r_err <= 1'b0;
    end else begin
      r_quat_valid <= w_done_quat;
      r_gyro_valid <= w_done_gyro;
      r_err        <= w_err;
      if (bus.pkt_start) begin
        r_hidx <= {1'b0, bus.rx_valid};
        if (bus.rx_valid) r_b0 <= bus.rx_byte;
      end else if (bus.rx_valid) begin
        case (r_state)
          HDR: begin
            r_hidx <= r_hidx + 2'd1;
            case (r_hidx)
              2'd0:    r_b0   <= bus.rx_byte;
              2'd1:    r_len  <= {bus.rx_byte[6:0], r_b0};
              2'd2:    r_chan <= bus.rx_byte;
              default: r_rem  <= r_len - 15'd4;
            endcase
          end
          RID: begin
            r_rem  <= w_rem_dec;
            r_bidx <= 4'd1;
            r_kind <= w_id_quat ? K_QUAT : (w_id_gyro ? K_GYRO : K_TS);
          end
          BODY: begin
            r_rem  <= w_rem_dec;
            r_bidx <= r_bidx + 4'd1;
            if (!r_bidx[0]) begin
              r_lsb <= bus.rx_byte;
            end else if (r_kind == K_QUAT) begin
              case (r_bidx)
                4'd5:    r_sh_qx <= w_pair;
                4'd7:    r_sh_qy <= w_pair;
                4'd9:    r_sh_qz <= w_pair;
                4'd11:   r_sh_qw <= w_pair;
                default: ;
              endcase
            end else if (r_kind == K_GYRO) begin
              case (r_bidx)
                4'd5:    r_sh_gx <= w_pair;
                4'd7:    r_sh_gy <= w_pair;
                default: ;
              endcase
            end
          end
          SKIP:    r_rem <= w_rem_dec;
          default: ;
        endcase
      end
      if (w_done_quat) begin
        r_qw <= r_sh_qw; r_qx <= r_sh_qx; r_qy <= r_sh_qy; r_qz <= r_sh_qz;
      end
      // The gyro z pair completes on the final body byte itself, so it bypasses the shadow.
      if (w_done_gyro) begin
        r_gx <= r_sh_gx; r_gy <= r_sh_gy; r_gz <= w_pair;
      end
    end
  end

  assign bus.quat_valid  = r_quat_valid;
  assign bus.gyro_valid  = r_gyro_valid;
  assign bus.parse_error = r_err;
  assign bus.quat_w = r_qw;
  assign bus.quat_x = r_qx;
  assign bus.quat_y = r_qy;
  assign bus.quat_z = r_qz;
  assign bus.gyro_x = r_gx;
  assign bus.gyro_y = r_gy;
  assign bus.gyro_z = r_gz;
endmodule

// File: tb/tb_bno085_report_parser.sv
// Randomized and directed bench for bno085_report_parser; expected strobes come from a
// packet-level model that walks each SHTP packet report by report.
module tb_bno085_report_parser;
  localparam logic [7:0] SENSOR = 8'd3;
  localparam logic [7:0] QID    = 8'h05;
  localparam logic [7:0] GID    = 8'h02;
  localparam logic [1:0] EV_QUAT = 2'd1, EV_GYRO = 2'd2, EV_ERR = 2'd3;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  kind;
    logic [15:0] a, b, c, d;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  logic [15:0] h_q[4];   // w, x, y, z
  logic [15:0] h_g[3];   // x, y, z

  bno085_report_parser_if bus();

  bno085_report_parser #(
    .SENSOR_CHANNEL(8'd3),
    .QUAT_REPORT_ID(8'h05),
    .GYRO_REPORT_ID(8'h02)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.quat_valid)
      obs_q.push_back({32'(cyc), EV_QUAT, bus.quat_w, bus.quat_x, bus.quat_y, bus.quat_z});
    if (bus.gyro_valid)
      obs_q.push_back({32'(cyc), EV_GYRO, bus.gyro_x, bus.gyro_y, bus.gyro_z, 16'h0});
    if (bus.parse_error)
      obs_q.push_back({32'(cyc), EV_ERR, 16'h0, 16'h0, 16'h0, 16'h0});
    cyc++;
  end

  function automatic ev_t mk(input int c, input logic [1:0] k, input logic [15:0] a, b, cc, d);
    return {32'(c), k, a, b, cc, d};
  endfunction

  function automatic string fmt(input ev_t e);
    return $sformatf("cyc=%0d kind=%0d %h %h %h %h", e.cyc, e.kind, e.a, e.b, e.c, e.d);
  endfunction

  function automatic logic [111:0] dut_out();
    return {bus.quat_w, bus.quat_x, bus.quat_y, bus.quat_z, bus.gyro_x, bus.gyro_y, bus.gyro_z};
  endfunction

  function automatic logic [111:0] held();
    return {h_q[0], h_q[1], h_q[2], h_q[3], h_g[0], h_g[1], h_g[2]};
  endfunction

  // Walks one packet as the sensor hub lays it out; acc[i] is the cycle byte i was accepted.
  function automatic void model(input logic [7:0] p[$], input int acc[$]);
    int n, len, pos, blen, last;
    logic [7:0] b1, id;
    n = p.size();
    if (n < 4) return;
    b1  = p[1];
    len = int'({b1[6:0], p[0]});
    if (len < 4) begin
      if (len != 0) exp_q.push_back(mk(acc[3], EV_ERR, '0, '0, '0, '0));
      return;
    end
    if (len == 4 || p[2] != SENSOR) return;
    pos = 4;
    while (pos < len && pos < n) begin
      id = p[pos];
      if (id == 8'hFB || id == 8'hFA) blen = 4;
      else if (id == QID)             blen = 13;
      else if (id == GID)             blen = 9;
      else return;
      last = pos + blen;
      if (last > len - 1) begin
        if (len - 1 < n) exp_q.push_back(mk(acc[len-1], EV_ERR, '0, '0, '0, '0));
        return;
      end
      if (last >= n) return;
      if (id == QID) begin
        h_q[0] = {p[pos+11], p[pos+10]};
        h_q[1] = {p[pos+5], p[pos+4]};
        h_q[2] = {p[pos+7], p[pos+6]};
        h_q[3] = {p[pos+9], p[pos+8]};
        exp_q.push_back(mk(acc[last], EV_QUAT, h_q[0], h_q[1], h_q[2], h_q[3]));
      end else if (id == GID) begin
        h_g[0] = {p[pos+5], p[pos+4]};
        h_g[1] = {p[pos+7], p[pos+6]};
        h_g[2] = {p[pos+9], p[pos+8]};
        exp_q.push_back(mk(acc[last], EV_GYRO, h_g[0], h_g[1], h_g[2], '0));
      end
      pos = last + 1;
    end
  endfunction

  function automatic void gen(output logic [7:0] p[$]);
    logic [7:0] pay[$];
    int len, k;
    repeat ($urandom_range(3, 0)) begin
      case ($urandom_range(4, 0))
        0:       begin pay.push_back(8'hFB); k = 4;  end
        1:       begin pay.push_back(8'hFA); k = 4;  end
        2:       begin pay.push_back(QID);   k = 13; end
        3:       begin pay.push_back(GID);   k = 9;  end
        default: begin pay.push_back(8'($urandom_range(8'hF0, 8'h06))); k = 6; end
      endcase
      repeat (k) pay.push_back(8'($urandom));
    end
    len = 4 + pay.size();
    case ($urandom_range(9, 0))
      0:       len = int'($urandom_range(4, 0));
      1:       if (len > 6) len = len - int'($urandom_range(3, 1));
      default: ;
    endcase
    p.delete();
    p.push_back(8'(len));
    p.push_back({1'($urandom), 7'(len >> 8)});
    p.push_back(($urandom_range(4, 0) == 0) ? 8'($urandom_range(7, 0)) : SENSOR);
    p.push_back(8'($urandom));
    foreach (pay[i]) p.push_back(pay[i]);
    case ($urandom_range(5, 0))
      0:       repeat ($urandom_range(3, 1)) if (p.size() > 4) void'(p.pop_back());
      1:       repeat ($urandom_range(3, 1)) p.push_back(8'($urandom));
      default: ;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.pkt_start = 1'b0;
      bus.rx_valid  = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] p[$], input int gap_max, input bit sep, output int acc[$]);
    acc.delete();
    if (sep) begin
      @(negedge clk);
      bus.pkt_start = 1'b1;
      bus.rx_valid  = 1'b0;
      @(posedge clk);
    end
    foreach (p[i]) begin
      if (i > 0 || sep) begin
        repeat ($urandom_range(gap_max, 0)) begin
          @(negedge clk);
          bus.pkt_start = 1'b0;
          bus.rx_valid  = 1'b0;
          bus.rx_byte   = 8'($urandom);
          @(posedge clk);
        end
      end
      @(negedge clk);
      bus.pkt_start = (i == 0) && !sep;
      bus.rx_valid  = 1'b1;
      bus.rx_byte   = p[i];
      @(posedge clk);
      acc.push_back(cyc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    total++;
    if ({bus.quat_valid, bus.gyro_valid, bus.parse_error} !== 3'b000) begin
      bad++;
      $display("FAIL reset_strobes: got %b, want 000", {bus.quat_valid, bus.gyro_valid, bus.parse_error});
    end
    total++;
    if (dut_out() !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h, want 0", dut_out());
    end
    rst = 1'b0;
    h_q = '{'0, '0, '0, '0};
    h_g = '{'0, '0, '0};
    idle(2);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_quat();
    logic [7:0] p[$];
    int acc[$];
    obs_q.delete(); exp_q.delete();
    p = '{8'h12, 8'h00, 8'h03, 8'h01, 8'h05, 8'h01, 8'h00, 8'h00, 8'h34, 8'h12,
          8'h78, 8'h56, 8'hBC, 8'h9A, 8'h00, 8'h40, 8'h00, 8'h00};
    send(p, 0, 1'b1, acc);
    model(p, acc);
    idle(3);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL quat_events: got %0d strobes, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL quat_ev%0d: got %s, want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    total++;
    if ({bus.quat_w, bus.quat_x, bus.quat_y, bus.quat_z} !== 64'h4000_1234_5678_9ABC) begin
      bad++; $display("FAIL quat_values: got %h %h %h %h, want 4000 1234 5678 9abc",
                      bus.quat_w, bus.quat_x, bus.quat_y, bus.quat_z);
    end
  endtask

  task automatic test_ts_gyro();
    logic [7:0] p[$];
    int acc[$];
    obs_q.delete(); exp_q.delete();
    p = '{8'h13, 8'h00, 8'h03, 8'h02, 8'hFB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
          8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h80};
    send(p, 2, 1'b0, acc);
    model(p, acc);
    idle(3);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL ts_gyro_events: got %0d strobes, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL ts_gyro_ev%0d: got %s, want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    total++;
    if ({bus.gyro_x, bus.gyro_y, bus.gyro_z} !== 48'hFFFF_0002_8000) begin
      bad++; $display("FAIL gyro_values: got %h %h %h, want ffff 0002 8000", bus.gyro_x, bus.gyro_y, bus.gyro_z);
    end
    total++;
    if ({bus.quat_w, bus.quat_x, bus.quat_y, bus.quat_z} !== 64'h4000_1234_5678_9ABC) begin
      bad++; $display("FAIL quat_held: got %h %h %h %h, want 4000 1234 5678 9abc",
                      bus.quat_w, bus.quat_x, bus.quat_y, bus.quat_z);
    end
  endtask

  task automatic test_foreign_and_truncated();
    logic [7:0] p[$];
    int acc[$];
    obs_q.delete(); exp_q.delete();
    // Foreign channel with quat-shaped payload, then trailing bytes that must be ignored in IDLE.
    p = '{8'h12, 8'h00, 8'h02, 8'h03, 8'h05, 8'h01, 8'h00, 8'h00, 8'h11, 8'h11,
          8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h00, 8'h00, 8'h05, 8'h01, 8'h00};
    send(p, 1, 1'b1, acc);
    model(p, acc);
    idle(2);
    p = '{8'h0A, 8'h00, 8'h03, 8'h04, 8'h05, 8'h01, 8'h00, 8'h00, 8'hAA, 8'hBB};
    send(p, 0, 1'b0, acc);
    model(p, acc);
    idle(3);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL skip_trunc_events: got %0d strobes, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL skip_trunc_ev%0d: got %s, want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    total++;
    if (dut_out() !== held()) begin
      bad++; $display("FAIL skip_trunc_held: got %h, want %h", dut_out(), held());
    end
  endtask

  task automatic test_abort_and_reset();
    logic [7:0] p[$];
    int acc[$];
    obs_q.delete(); exp_q.delete();
    p = '{8'h12, 8'h00, 8'h03, 8'h05, 8'h05, 8'h01, 8'h00, 8'h00, 8'h77, 8'h77, 8'h66};
    send(p, 0, 1'b0, acc);
    model(p, acc);
    p = '{8'h0E, 8'h00, 8'h03, 8'h06, 8'h02, 8'h09, 8'h00, 8'h00, 8'h10, 8'h00,
          8'h20, 8'hF0, 8'h30, 8'h7F};
    send(p, 0, 1'b0, acc);
    model(p, acc);
    idle(3);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL abort_events: got %0d strobes, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL abort_ev%0d: got %s, want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    total++;
    if ({bus.gyro_x, bus.gyro_y, bus.gyro_z} !== 48'h0010_F020_7F30) begin
      bad++; $display("FAIL abort_gyro: got %h %h %h, want 0010 f020 7f30", bus.gyro_x, bus.gyro_y, bus.gyro_z);
    end
    obs_q.delete();
    p = '{8'h12, 8'h00, 8'h03, 8'h07, 8'h05, 8'h01, 8'h00, 8'h00, 8'h55, 8'h55, 8'h66, 8'h66};
    send(p, 0, 1'b0, acc);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL reset_mid_strobes: got %0d strobes, want 0", obs_q.size());
    end
    total++;
    if (dut_out() !== '0) begin
      bad++; $display("FAIL reset_mid_data: got %h, want 0", dut_out());
    end
    h_q = '{'0, '0, '0, '0};
    h_g = '{'0, '0, '0};
  endtask

  task automatic test_back_to_back();
    logic [7:0] p[$];
    int acc[$];
    obs_q.delete(); exp_q.delete();
    p = '{8'h12, 8'h00, 8'h03, 8'h08, 8'h05, 8'h02, 8'h03, 8'h00, 8'h01, 8'h80,
          8'h02, 8'h40, 8'h03, 8'h20, 8'h04, 8'h10, 8'h03, 8'h00};
    send(p, 0, 1'b0, acc);
    model(p, acc);
    p = '{8'h0E, 8'h00, 8'h03, 8'h09, 8'h02, 8'h00, 8'h00, 8'h00, 8'hCD, 8'hAB,
          8'h34, 8'h12, 8'h01, 8'h00};
    send(p, 0, 1'b0, acc);
    model(p, acc);
    p = '{8'h12, 8'h00, 8'h03, 8'h0A, 8'h01, 8'h01, 8'h00, 8'h00, 8'h99, 8'h99,
          8'h88, 8'h88, 8'h77, 8'h77, 8'h66, 8'h66, 8'h00, 8'h00};
    send(p, 0, 1'b0, acc);
    model(p, acc);
    idle(3);
    total++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      bad++; $display("FAIL b2b_events: got %0d strobes, want 2 (model %0d)", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_ev%0d: got %s, want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    total++;
    if (dut_out() !== held()) begin
      bad++; $display("FAIL b2b_held: got %h, want %h", dut_out(), held());
    end
  endtask

  task automatic test_random();
    logic [7:0] p[$];
    int acc[$];
    obs_q.delete(); exp_q.delete();
    repeat (60) begin
      gen(p);
      send(p, int'($urandom_range(2, 0)), 1'($urandom), acc);
      model(p, acc);
      idle(int'($urandom_range(2, 0)));
    end
    idle(3);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_events: got %0d strobes, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rand_ev%0d: got %s, want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    total++;
    if (dut_out() !== held()) begin
      bad++; $display("FAIL rand_held: got %h, want %h", dut_out(), held());
    end
  endtask

  initial begin
    bus.pkt_start = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    test_reset();
    test_quat();
    test_ts_gyro();
    test_foreign_and_truncated();
    test_abort_and_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
